// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, sizes and GF(2^8) helpers for the iterative cipher core.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef logic [3:0] round_t;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as a^254 (multiplicative inverse, 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/KeyExp.sv
// rtl/KeyExp.sv - combinational AES key expansion producing all NR+1 round keys.
module KeyExp #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic [32*NK-1:0] key,
  output logic [127:0]     round_keys [0:NR]
);
  import aes_pkg::*;

  localparam int NW = 4 * (NR + 1);

  function automatic logic [32*NW-1:0] expand(input logic [32*NK-1:0] k);
    logic [31:0]      w [NW];
    logic [31:0]      t;
    logic [7:0]       rcon;
    logic [32*NW-1:0] flat;
    w    = '{default: '0};
    t    = '0;
    rcon = 8'h01;
    flat = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < NK) begin
        w[i] = k[32*(NK-1-i) +: 32];
      end else begin
        t = w[i-1];
        if (i % NK == 0) begin
          t    = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
          rcon = xtime(rcon);
        end else if (NK > 6 && i % NK == 4) begin
          t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        end
        w[i] = w[i-NK] ^ t;
      end
      flat[32*(NW-1-i) +: 32] = w[i];
    end
    return flat;
  endfunction

  logic [32*NW-1:0] flat_w;
  assign flat_w = expand(key);

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign round_keys[r] = flat_w[128*(NR-r) +: 128];
  end

endmodule

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one AES round; last_round drops MixColumns for the final round.
module aes_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_in,
  input  logic [AES_BLOCK_W-1:0] round_key,
  input  logic                   last_round,
  output logic [AES_BLOCK_W-1:0] state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // byte i sits at row i%4, column i/4
  always_comb begin
    sb        = '{default: '0};
    sr        = '{default: '0};
    mc        = '{default: '0};
    state_out = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(state_in[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++)
      state_out[127-8*i -: 8] = (last_round ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES-128/192/256 encryptor, one round per clock.
// Optional abort input enabled by defining AES_ABORT_EN.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic [32*NK-1:0]       in_key,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data
`ifdef AES_ABORT_EN
  ,
  input  logic                   abort
`endif
);

  localparam int     NR   = nr_of(NK);
  localparam round_t NR_R = round_t'(NR);

  state_e                 state_q, state_d;
  round_t                 round_q, round_d;
  logic [AES_BLOCK_W-1:0] st_q, st_d;
  logic [AES_BLOCK_W-1:0] out_data_q, out_data_d;
  logic [32*NK-1:0]       key_q, key_d;
  logic                   out_valid_q, out_valid_d;

  logic [AES_BLOCK_W-1:0] rk [0:NR];
  logic [AES_BLOCK_W-1:0] rk_cur;
  logic [AES_BLOCK_W-1:0] round_out;
  logic                   last_round;
  logic                   abort_w;
  logic                   accept;

`ifdef AES_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  KeyExp #(.NK(NK), .NR(NR)) u_key_exp (
    .key        (key_q),
    .round_keys (rk)
  );

  aes_round u_round (
    .state_in   (st_q),
    .round_key  (rk_cur),
    .last_round (last_round),
    .state_out  (round_out)
  );

  assign last_round = (round_q == NR_R);

  always_comb begin
    rk_cur = '0;
    for (int i = 0; i <= NR; i++)
      if (round_q == round_t'(i)) rk_cur = rk[i];
  end

  // in DONE the next block may load on the same edge the ciphertext is taken
  assign in_ready = !rst && ((state_q == IDLE) || (state_q == DONE && out_ready && !abort_w));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    st_d        = st_q;
    key_d       = key_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      RUN: begin
        st_d = round_out;
        if (last_round) begin
          state_d     = DONE;
          round_d     = '0;
          out_valid_d = 1'b1;
          out_data_d  = round_out;
        end else begin
          round_d = round_q + round_t'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (accept) begin
      key_d   = in_key;
      st_d    = in_data ^ in_key[32*NK-1 -: AES_BLOCK_W];
      round_d = round_t'(1);
      state_d = RUN;
    end
    if (abort_w && state_q != IDLE) begin
      state_d     = IDLE;
      round_d     = '0;
      st_d        = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      round_q     <= '0;
      st_q        <= '0;
      key_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      st_q        <= st_d;
      key_q       <= key_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
